// File: rtl/tower_core.sv
// tower_core: game tower entity holding health, deploy position and life state (QI/QDeploy/QAlive/QDead).
// Optional per-tick health regeneration in QAlive is enabled by defining TOWER_REGEN_EN.
module tower_core #(
  parameter int HP_W        = 8,
  parameter int MAX_HP      = 255,
  parameter int N_ATK       = 2,
  parameter int DMG_W       = 8,
  parameter int POS_W       = 9,
  parameter int DEAD_HOLD   = 10,
  parameter int REGEN_TICKS = 16,
  parameter int REGEN_AMT   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gameTick,
  input  logic                   startLevel,
  input  logic                   player,
  input  logic [N_ATK*DMG_W-1:0] damageIn,
  input  logic [N_ATK-1:0]       attackSCEN,
  output logic [HP_W-1:0]        health,
  output logic [POS_W-1:0]       position,
  output logic                   isPlayer,
  output logic                   alive,
  output logic                   dead,
  output logic                   levelComplete,
  output logic                   hitFlag
);

  localparam int TW  = DMG_W + $clog2(N_ATK) + 1;
  localparam int CW  = ((TW > HP_W) ? TW : HP_W) + 2;
  localparam int DCW = $clog2(DEAD_HOLD + 1);

  typedef enum logic [3:0] {
    QI      = 4'b0001,
    QDeploy = 4'b0010,
    QAlive  = 4'b0100,
    QDead   = 4'b1000
  } state_t;

  state_t           r_state, w_next;
  logic [HP_W-1:0]  r_health, w_health;
  logic [POS_W-1:0] r_pos, w_pos;
  logic             r_isp, w_isp;
  logic             r_alive, r_dead, r_lvl, r_hit, w_hit;
  logic [DCW-1:0]   r_dcnt, w_dcnt;
  logic [TW-1:0]    w_total;
  logic [CW-1:0]    w_total_c, w_health_c;
  logic             w_regen_step;
  logic [HP_W-1:0]  w_regen_hp;

  // Sum of strobed damage channels, wide enough that it can never wrap
  always_comb begin
    w_total = '0;
    for (int k = 0; k < N_ATK; k++) begin
      if (attackSCEN[k]) begin
        w_total = w_total + TW'(damageIn[k*DMG_W +: DMG_W]);
      end else begin
        w_total = w_total;
      end
    end
  end

  assign w_total_c  = CW'(w_total);
  assign w_health_c = CW'(r_health);

`ifdef TOWER_REGEN_EN
  localparam int RCW = $clog2(REGEN_TICKS + 1);
  logic [RCW-1:0] r_rcnt;
  logic [CW-1:0]  w_regen_sum;

  assign w_regen_step = gameTick && (r_rcnt == RCW'(REGEN_TICKS - 1));
  assign w_regen_sum  = w_health_c - w_total_c + CW'(REGEN_AMT);
  assign w_regen_hp   = (w_regen_sum > CW'(MAX_HP)) ? HP_W'(MAX_HP) : HP_W'(w_regen_sum);

  // Regen tick counter; only runs while staying in QAlive
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rcnt <= '0;
    end else if ((r_state != QAlive) || (w_next != QAlive)) begin
      r_rcnt <= '0;
    end else if (gameTick) begin
      r_rcnt <= w_regen_step ? '0 : (r_rcnt + RCW'(1));
    end else begin
      r_rcnt <= r_rcnt;
    end
  end
`else
  assign w_regen_step = 1'b0;
  assign w_regen_hp   = r_health;
`endif

  // Next-state and next-value logic for the tower FSM
  always_comb begin
    w_next   = QI;
    w_health = r_health;
    w_pos    = r_pos;
    w_isp    = r_isp;
    w_hit    = 1'b0;
    w_dcnt   = r_dcnt;
    case (r_state)
      QI: begin
        w_health = HP_W'(MAX_HP);
        w_dcnt   = '0;
        if (startLevel) begin
          w_isp  = player;
          w_next = QDeploy;
        end else begin
          w_next = QI;
        end
      end
      QDeploy: begin
        w_pos  = r_isp ? {POS_W{1'b1}} : {POS_W{1'b0}};
        w_next = QAlive;
      end
      QAlive: begin
        w_hit = (w_total != '0);
        if (w_total_c >= w_health_c) begin
          w_health = '0;
          w_next   = QDead;
        end else if (w_regen_step) begin
          w_health = w_regen_hp;
          w_next   = QAlive;
        end else begin
          w_health = HP_W'(w_health_c - w_total_c);
          w_next   = QAlive;
        end
      end
      QDead: begin
        w_health = '0;
        if (gameTick && (r_dcnt == DCW'(DEAD_HOLD - 1))) begin
          w_next   = QI;
          w_health = HP_W'(MAX_HP);
          w_dcnt   = '0;
        end else if (gameTick) begin
          w_next = QDead;
          w_dcnt = r_dcnt + DCW'(1);
        end else begin
          w_next = QDead;
        end
      end
      default: begin
        w_next   = QI;
        w_health = HP_W'(MAX_HP);
        w_dcnt   = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= QI;
    end else begin
      r_state <= w_next;
    end
  end

  // Registered datapath and status outputs, aligned with the state they describe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_health <= HP_W'(MAX_HP);
      r_pos    <= '0;
      r_isp    <= 1'b0;
      r_alive  <= 1'b0;
      r_dead   <= 1'b0;
      r_lvl    <= 1'b0;
      r_hit    <= 1'b0;
      r_dcnt   <= '0;
    end else begin
      r_health <= w_health;
      r_pos    <= w_pos;
      r_isp    <= w_isp;
      r_alive  <= (w_next == QAlive);
      r_dead   <= (w_next == QDead);
      r_lvl    <= (w_next == QDead);
      r_hit    <= w_hit;
      r_dcnt   <= w_dcnt;
    end
  end

  assign health        = r_health;
  assign position      = r_pos;
  assign isPlayer      = r_isp;
  assign alive         = r_alive;
  assign dead          = r_dead;
  assign levelComplete = r_lvl;
  assign hitFlag       = r_hit;

endmodule

// File: tb/tb_tower_core.sv
// Randomised scoreboard bench for tower_core: a behavioural tower model queues expected outputs,
// and a negedge monitor pops and compares them against the DUT every cycle.
module tb_tower_core;
  localparam int HP_W = 8, MAX_HP = 255, N_ATK = 2, DMG_W = 8, POS_W = 9;
  localparam int DEAD_HOLD = 10, REGEN_TICKS = 16, REGEN_AMT = 1;

  logic clk = 1'b0;
  logic reset, gameTick, startLevel, player;
  logic [N_ATK*DMG_W-1:0] damageIn;
  logic [N_ATK-1:0] attackSCEN;
  logic [HP_W-1:0] health;
  logic [POS_W-1:0] position;
  logic isPlayer, alive, dead, levelComplete, hitFlag;

  tower_core #(
    .HP_W(HP_W), .MAX_HP(MAX_HP), .N_ATK(N_ATK), .DMG_W(DMG_W), .POS_W(POS_W),
    .DEAD_HOLD(DEAD_HOLD), .REGEN_TICKS(REGEN_TICKS), .REGEN_AMT(REGEN_AMT)
  ) dut (
    .clk(clk), .reset(reset), .gameTick(gameTick), .startLevel(startLevel), .player(player),
    .damageIn(damageIn), .attackSCEN(attackSCEN), .health(health), .position(position),
    .isPlayer(isPlayer), .alive(alive), .dead(dead), .levelComplete(levelComplete), .hitFlag(hitFlag)
  );

  always #5 clk = ~clk;

  logic [21:0] sb_q[$];
  logic [21:0] mon_exp, mon_act;
  int total_cnt = 0;
  int bad_cnt = 0;

  // Behavioural model: phase 0=idle 1=deploy 2=alive 3=dead
  int m_phase = 0, m_health = MAX_HP, m_pos = 0, m_isp = 0, m_hit = 0, m_dcnt = 0, m_rcnt = 0;

  task automatic step(input bit rst, input bit tick, input bit start, input bit pl,
                      input int d0, input int d1, input bit s0, input bit s1);
    int  tot;
    bit  regen;
    reset = rst; gameTick = tick; startLevel = start; player = pl;
    damageIn = {8'(d1), 8'(d0)};
    attackSCEN = {s1, s0};
    m_hit = 0;
    if (rst) begin
      m_phase = 0; m_health = MAX_HP; m_pos = 0; m_isp = 0; m_dcnt = 0; m_rcnt = 0;
    end else begin
      case (m_phase)
        0: begin
          m_health = MAX_HP;
          if (start) begin m_isp = pl; m_phase = 1; end
        end
        1: begin
          m_pos = m_isp ? (1 << POS_W) - 1 : 0;
          m_phase = 2;
          m_rcnt = 0;
        end
        2: begin
          tot = (s0 ? d0 : 0) + (s1 ? d1 : 0);
          m_hit = (tot != 0);
          regen = 0;
`ifdef TOWER_REGEN_EN
          if (tick) begin
            m_rcnt++;
            if (m_rcnt == REGEN_TICKS) begin m_rcnt = 0; regen = 1; end
          end
`endif
          if (tot >= m_health) begin
            m_health = 0; m_phase = 3; m_rcnt = 0; m_dcnt = 0;
          end else if (regen) begin
            m_health = m_health - tot + REGEN_AMT;
            if (m_health > MAX_HP) m_health = MAX_HP;
          end else begin
            m_health = m_health - tot;
          end
        end
        default: begin
          if (tick) begin
            m_dcnt++;
            if (m_dcnt == DEAD_HOLD) begin m_phase = 0; m_health = MAX_HP; m_dcnt = 0; end
          end
        end
      endcase
    end
    sb_q.push_back({8'(m_health), 9'(m_pos), 1'(m_isp), (m_phase == 2), (m_phase == 3),
                    (m_phase == 3), 1'(m_hit)});
    @(posedge clk);
    #1;
  endtask

  // Random alive-phase traffic; stops early once the model reports death
  task automatic rnd_alive(input int n, input int maxd, input int strobe_pct);
    for (int i = 0; i < n; i++) begin
      if (m_phase != 2) break;
      step(1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
           $urandom_range(0, maxd), $urandom_range(0, maxd),
           ($urandom_range(0, 99) < strobe_pct), ($urandom_range(0, 99) < strobe_pct));
    end
  endtask

  task automatic wait_idle(input bit always_tick);
    for (int i = 0; i < 200; i++) begin
      if (m_phase == 0) break;
      step(1'b0, always_tick ? 1'b1 : ($urandom_range(0, 1) == 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 1), $urandom_range(0, 1));
    end
  endtask

  // Monitor: outputs are presented every cycle, compare against the oldest expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_exp = sb_q.pop_front();
      mon_act = {health, position, isPlayer, alive, dead, levelComplete, hitFlag};
      total_cnt++;
      if (mon_act !== mon_exp) begin
        bad_cnt++;
        $display("FAIL outputs t=%0t got h=%0d pos=%h isP=%b alive=%b dead=%b lc=%b hit=%b, want h=%0d pos=%h isP=%b alive=%b dead=%b lc=%b hit=%b",
                 $time, mon_act[21:14], mon_act[13:5], mon_act[4], mon_act[3], mon_act[2],
                 mon_act[1], mon_act[0], mon_exp[21:14], mon_exp[13:5], mon_exp[4], mon_exp[3],
                 mon_exp[2], mon_exp[1], mon_exp[0]);
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 9, 9, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, $urandom_range(1, 255), $urandom_range(1, 255), 1'b1, 1'b1);
    // Level 1: player tower, directed hits then random chip damage
    step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 50, 50, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 10, 20, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 77, 0, 1'b0, 1'b1);
    rnd_alive(40, 2, 25);
    if (m_phase == 2 && m_health > 30) step(1'b0, 1'b0, 1'b0, 1'b0, m_health - 30, 0, 1'b1, 1'b0);
    if (m_phase == 2) step(1'b0, 1'b0, 1'b0, 1'b0, m_health, 0, 1'b1, 1'b0);
    wait_idle(1'b0);
    // Level 2: enemy tower killed by a double hit larger than its health
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 200, 200, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    // Level 3: fresh dwell after reset-in-dead, long regen-capable run, then heavy random damage
    step(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    rnd_alive(60, 255, 15);
    if (m_phase == 2) step(1'b0, 1'b0, 1'b0, 1'b0, 255, 255, 1'b1, 1'b1);
    wait_idle(1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    total_cnt++;
    if (sb_q.size() != 0) begin
      bad_cnt++;
      $display("FAIL drain got %0d pending entries, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
